// File: rtl/axi_req_arbiter.sv
// Arbiter sharing one AXI master bridge among NREQ requesters.
// Define ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module axi_req_arbiter #(
   parameter int NREQ = 3,
   parameter int IDW  = 2,
   parameter int AW   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_en,
   input  logic [4*NREQ-1:0]   req_wen,
   input  logic [AW*NREQ-1:0]  req_addr,
   output logic [NREQ-1:0]     grant,
   output logic [NREQ-1:0]     refresh,
   output logic                busy,
   output logic                bus_en,
   output logic [3:0]          bus_wen,
   output logic [AW-1:0]       bus_addr,
   output logic [IDW-1:0]      bus_id,
   input  logic                bus_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] refresh_q, refresh_d;
   logic            bus_en_q, bus_en_d;
   logic [3:0]      bus_wen_q, bus_wen_d;
   logic [AW-1:0]   bus_addr_q, bus_addr_d;
   logic [IDW-1:0]  bus_id_q, bus_id_d;
   logic [IDW-1:0]  win_idx;

`ifdef ARB_RR_EN
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

   // Search starts at rr_ptr and wraps, so the last winner ranks lowest.
   always_comb begin
      int idx;
      logic found;
      win_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NREQ;
         if (!found && req_en[idx]) begin
            found   = 1'b1;
            win_idx = IDW'(idx);
         end
      end
   end
`else
   always_comb begin
      win_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_en[i]) win_idx = IDW'(i);
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      refresh_d  = refresh_q;
      bus_en_d   = bus_en_q;
      bus_wen_d  = bus_wen_q;
      bus_addr_d = bus_addr_q;
      bus_id_d   = bus_id_q;
`ifdef ARB_RR_EN
      rr_ptr_d   = rr_ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|req_en) begin
               state_d          = ISSUE;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               bus_en_d         = 1'b1;
               bus_wen_d        = req_wen[4*int'(win_idx) +: 4];
               bus_addr_d       = req_addr[AW*int'(win_idx) +: AW];
               bus_id_d         = win_idx;
`ifdef ARB_RR_EN
               rr_ptr_d         = IDW'((int'(win_idx) + 1) % NREQ);
`endif
            end
         end
         ISSUE: begin
            if (bus_done) begin
               state_d    = DONE;
               bus_en_d   = 1'b0;
               bus_wen_d  = '0;
               bus_addr_d = '0;
               refresh_d  = grant_q;
            end
         end
         DONE: begin
            // No arbitration here: the owner gets a cycle to drop its request.
            state_d   = IDLE;
            refresh_d = '0;
            grant_d   = '0;
            bus_id_d  = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         refresh_q  <= '0;
         bus_en_q   <= 1'b0;
         bus_wen_q  <= '0;
         bus_addr_q <= '0;
         bus_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         refresh_q  <= refresh_d;
         bus_en_q   <= bus_en_d;
         bus_wen_q  <= bus_wen_d;
         bus_addr_q <= bus_addr_d;
         bus_id_q   <= bus_id_d;
      end
   end

`ifdef ARB_RR_EN
   always_ff @(posedge clk) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end
`endif

   assign grant    = grant_q;
   assign refresh  = refresh_q;
   assign busy     = (state_q != IDLE);
   assign bus_en   = bus_en_q;
   assign bus_wen  = bus_wen_q;
   assign bus_addr = bus_addr_q;
   assign bus_id   = bus_id_q;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed table-driven bench for axi_req_arbiter (NREQ=3).
module tb_axi_req_arbiter;

   localparam logic [31:0] A0 = 32'h1000_0040;
   localparam logic [31:0] A1 = 32'hBFAF_8000;
   localparam logic [31:0] A2 = 32'h1FC0_0004;
   localparam logic [31:0] AX = 32'h1234_5678;
   localparam logic [11:0] W  = 12'h30F;
   localparam logic [11:0] WF = 12'hF0F;

   logic        clk;
   logic        rst;
   logic [2:0]  req_en;
   logic [11:0] req_wen;
   logic [95:0] req_addr;
   logic [2:0]  grant;
   logic [2:0]  refresh;
   logic        busy;
   logic        bus_en;
   logic [3:0]  bus_wen;
   logic [31:0] bus_addr;
   logic [1:0]  bus_id;
   logic        bus_done;

   int n_tests;
   int n_fail;

   axi_req_arbiter #(.NREQ(3), .IDW(2), .AW(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_en   (req_en),
      .req_wen  (req_wen),
      .req_addr (req_addr),
      .grant    (grant),
      .refresh  (refresh),
      .busy     (busy),
      .bus_en   (bus_en),
      .bus_wen  (bus_wen),
      .bus_addr (bus_addr),
      .bus_id   (bus_id),
      .bus_done (bus_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [2:0]  en;
      logic [11:0] wen;
      logic [31:0] a2;
      logic        done;
      logic [2:0]  gnt;
      logic [2:0]  rfs;
      logic        bsy;
      logic        ben;
      logic [3:0]  bwen;
      logic [31:0] baddr;
      logic [1:0]  bid;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      logic r, logic [2:0] en, logic [11:0] wen, logic [31:0] a2,
      logic done, logic [2:0] gnt, logic [2:0] rfs, logic bsy,
      logic ben, logic [3:0] bwen, logic [31:0] baddr, logic [1:0] bid);
      vec_t v;
      v.r = r; v.en = en; v.wen = wen; v.a2 = a2; v.done = done;
      v.gnt = gnt; v.rfs = rfs; v.bsy = bsy; v.ben = ben;
      v.bwen = bwen; v.baddr = baddr; v.bid = bid;
      return v;
   endfunction

   task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_inv(string name);
      logic ok;
      ok = ($onehot0(grant) && $onehot0(refresh) &&
            ((refresh & ~grant) == 3'b000) && (!bus_en || grant != 3'b000));
      chk(name, {47'd0, ok}, 48'd1);
   endtask

   task automatic drive(logic r, logic [2:0] en, logic [11:0] wen,
                        logic [31:0] a2, logic done);
      rst      = r;
      req_en   = en;
      req_wen  = wen;
      req_addr = {a2, A1, A0};
      bus_done = done;
   endtask

   initial begin
      int exp_id;
      string nm;
      n_tests = 0;
      n_fail  = 0;
      drive(1'b1, 3'b111, W, A2, 1'b0);

      // T1 reset, 1-cycle transaction
      vecs.push_back(mk(1, 3'b111, W, A2, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3'b111, W, A2, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b111, W, A2, 0, 1, 0, 1, 1, 4'hF, A0, 0));
      vecs.push_back(mk(0, 3'b000, W, A2, 1, 1, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, W, A2, 0, 0, 0, 0, 0, 0, 0, 0));
      // T2 single read
      vecs.push_back(mk(0, 3'b010, W, A2, 0, 2, 0, 1, 1, 0, A1, 1));
      vecs.push_back(mk(0, 3'b010, W, A2, 0, 2, 0, 1, 1, 0, A1, 1));
      vecs.push_back(mk(0, 3'b010, W, A2, 0, 2, 0, 1, 1, 0, A1, 1));
      vecs.push_back(mk(0, 3'b010, W, A2, 0, 2, 0, 1, 1, 0, A1, 1));
      vecs.push_back(mk(0, 3'b010, W, A2, 1, 2, 2, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 3'b000, W, A2, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, W, A2, 1, 0, 0, 0, 0, 0, 0, 0));
      // T4 write forwarding, request changes ignored during ISSUE
      vecs.push_back(mk(0, 3'b100, W, A2, 0, 4, 0, 1, 1, 4'h3, A2, 2));
      vecs.push_back(mk(0, 3'b100, WF, AX, 0, 4, 0, 1, 1, 4'h3, A2, 2));
      vecs.push_back(mk(0, 3'b100, W, A2, 1, 4, 4, 1, 0, 0, 0, 2));
      vecs.push_back(mk(0, 3'b100, W, A2, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, W, A2, 0, 0, 0, 0, 0, 0, 0, 0));
      // T5 owner drops req_en during ISSUE
      vecs.push_back(mk(0, 3'b001, W, A2, 0, 1, 0, 1, 1, 4'hF, A0, 0));
      vecs.push_back(mk(0, 3'b000, W, A2, 0, 1, 0, 1, 1, 4'hF, A0, 0));
      vecs.push_back(mk(0, 3'b000, W, A2, 0, 1, 0, 1, 1, 4'hF, A0, 0));
      vecs.push_back(mk(0, 3'b000, W, A2, 1, 1, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, W, A2, 0, 0, 0, 0, 0, 0, 0, 0));
      // T6 reset mid-ISSUE
      vecs.push_back(mk(0, 3'b010, W, A2, 0, 2, 0, 1, 1, 0, A1, 1));
      vecs.push_back(mk(1, 3'b010, W, A2, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, W, A2, 0, 0, 0, 0, 0, 0, 0, 0));
      // two-way contention, fixed priority
      vecs.push_back(mk(0, 3'b110, W, A2, 0, 2, 0, 1, 1, 0, A1, 1));
      vecs.push_back(mk(0, 3'b110, W, A2, 1, 2, 2, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 3'b100, W, A2, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b100, W, A2, 0, 4, 0, 1, 1, 4'h3, A2, 2));
      vecs.push_back(mk(0, 3'b000, W, A2, 1, 4, 4, 1, 0, 0, 0, 2));
      vecs.push_back(mk(0, 3'b000, W, A2, 0, 0, 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].r, vecs[i].en, vecs[i].wen, vecs[i].a2, vecs[i].done);
         @(posedge clk);
         #1;
         nm = $sformatf("row%0d", i);
         chk(nm,
             {grant, refresh, busy, bus_en, bus_wen, bus_addr, bus_id},
             {vecs[i].gnt, vecs[i].rfs, vecs[i].bsy, vecs[i].ben,
              vecs[i].bwen, vecs[i].baddr, vecs[i].bid});
         chk_inv({nm, "_inv"});
      end

      // T3 all three requesting continuously
      for (int t = 0; t < 4; t++) begin
`ifdef ARB_RR_EN
         exp_id = t % 3;
`else
         exp_id = 0;
`endif
         @(negedge clk);
         drive(1'b0, 3'b111, W, A2, 1'b0);
         @(posedge clk);
         #1;
         chk($sformatf("t3_grant%0d", t),
             {43'd0, bus_en, grant, bus_id},
             {43'd0, 1'b1, 3'(1 << exp_id), 2'(exp_id)});
         @(negedge clk);
         bus_done = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("t3_refresh%0d", t),
             {42'd0, refresh, grant},
             {42'd0, 3'(1 << exp_id), 3'(1 << exp_id)});
         chk_inv($sformatf("t3_inv%0d", t));
         @(negedge clk);
         bus_done = 1'b0;
         @(posedge clk);
         #1;
         chk($sformatf("t3_idle%0d", t),
             {42'd0, grant, refresh},
             48'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
